// File: rtl/mem_loader_pkg.sv
// Shared types and constants for the boot-time data-memory loader.
// The FSM state encoding and word geometry are used by both the loader and its byte packer.
package mem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      WRITE   = 3'd2,
      RELEASE = 3'd3,
      RUN     = 3'd4
   } state_t;

   localparam int WORD_BYTES = 4;
   localparam int ADDR_STEP  = 4;

   // Byte address of word number idx; wraps modulo 2^32.
   function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [15:0] idx);
      return base + (32'(idx) * 32'(ADDR_STEP));
   endfunction

endpackage

// File: rtl/mem_loader_byte_packer.sv
// Little-endian byte-to-word packer: byte idx lands in bits 8*idx+7:8*idx.
// word_full flags the transfer that completes a word; packed_word already includes that byte.
module byte_packer
   import mem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        load,
   input  logic [7:0]  data,
   output logic [31:0] packed_word,
   output logic        word_full
);

   logic [1:0]  byte_idx;
   logic [31:0] lanes;

   always_comb begin
      packed_word = lanes;
      if (load) begin
         packed_word[{byte_idx, 3'b000} +: 8] = data;
      end
   end

   assign word_full = load && (byte_idx == 2'(WORD_BYTES - 1));

   // The 2-bit index wraps to lane 0 on its own after the last lane.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         byte_idx <= 2'd0;
         lanes    <= 32'd0;
      end else if (clear) begin
         byte_idx <= 2'd0;
         lanes    <= 32'd0;
      end else if (load) begin
         byte_idx <= byte_idx + 2'd1;
         lanes    <= packed_word;
      end
   end

endmodule

// File: rtl/mem_loader.sv
// Boot loader: packs a byte stream into words, writes them through the CPU's external
// memory port while holding the CPU in reset, then releases it after a settle delay.
module mem_loader
   import mem_loader_pkg::*;
#(
   parameter int          NUM_WORDS     = 64,
   parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
   parameter int          RELEASE_DELAY = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic        byte_ready,
   output logic        cpu_reset,
   output logic        Ext_MemWrite,
   output logic [31:0] Ext_WriteData,
   output logic [31:0] Ext_DataAdr,
   output logic        busy,
   output logic        done,
   output logic [15:0] word_count
);

   localparam int RW = (RELEASE_DELAY < 2) ? 1 : $clog2(RELEASE_DELAY + 1);

   state_t        state, next_state;
   logic [RW-1:0] rel_cnt;
   logic          transfer;
   logic          start_load;
   logic          clear_pack;
   logic          last_word;
   logic          word_full;
   logic [31:0]   packed_word;

   // Byte handshake: a byte moves on any rising edge where byte_valid && byte_ready.
   assign byte_ready   = (state == COLLECT);
   assign transfer     = byte_valid && byte_ready;
   assign cpu_reset    = (state != RUN);
   assign Ext_MemWrite = (state == WRITE);
   assign busy         = (state == COLLECT) || (state == WRITE) || (state == RELEASE);

   // abort outranks start; start is only honoured when no load is in progress.
   assign start_load = start && !abort && ((state == IDLE) || (state == RUN));
   assign clear_pack = start_load || ((state == COLLECT) && abort);
   assign last_word  = ((word_count + 16'd1) == 16'(NUM_WORDS));

   byte_packer u_packer (
      .clk         (clk),
      .rst         (reset),
      .clear       (clear_pack),
      .load        (transfer),
      .data        (byte_data),
      .packed_word (packed_word),
      .word_full   (word_full)
   );

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (abort)           next_state = RELEASE;
            else if (start_load) next_state = COLLECT;
         end
         COLLECT: begin
            if (abort)          next_state = RELEASE;
            else if (word_full) next_state = WRITE;
         end
         WRITE: begin
            if (abort || last_word) next_state = RELEASE;
            else                    next_state = COLLECT;
         end
         RELEASE: begin
            if (rel_cnt == '0) next_state = RUN;
         end
         RUN: begin
            if (start_load) next_state = COLLECT;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= next_state;
   end

   // Release counter runs RELEASE_DELAY..0, so RELEASE lasts RELEASE_DELAY+1 cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rel_cnt <= '0;
      end else if ((next_state == RELEASE) && (state != RELEASE)) begin
         rel_cnt <= RW'(RELEASE_DELAY);
      end else if ((state == RELEASE) && (rel_cnt != '0)) begin
         rel_cnt <= rel_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         word_count <= 16'd0;
         done       <= 1'b0;
      end else begin
         if (start_load) begin
            word_count <= 16'd0;
            done       <= 1'b0;
         end else begin
            if (state == WRITE) word_count <= word_count + 16'd1;
            if ((state == RELEASE) && (next_state == RUN))
               done <= (word_count == 16'(NUM_WORDS));
         end
      end
   end

   // Write data/address are captured with the completing byte so they are stable during WRITE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         Ext_WriteData <= 32'd0;
         Ext_DataAdr   <= BASE_ADDR;
      end else if ((state == COLLECT) && word_full && !abort) begin
         Ext_WriteData <= packed_word;
         Ext_DataAdr   <= word_addr(BASE_ADDR, word_count);
      end
   end

endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: a driver feeds bytes, expected writes are queued and
// a negedge monitor pops and compares every Ext_MemWrite strobe.
module tb_mem_loader;

   localparam int          NW = 2;
   localparam logic [31:0] BA = 32'h0000_0100;
   localparam int          RD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        cpu_reset;
   logic        Ext_MemWrite;
   logic [31:0] Ext_WriteData;
   logic [31:0] Ext_DataAdr;
   logic        busy;
   logic        done;
   logic [15:0] word_count;

   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   int          strobe_cnt = 0;
   int          exp_writes = 0;
   int          last_strobe_cyc = 0;
   int          fall_cyc;
   int          ab_cyc;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;

   mem_loader #(
      .NUM_WORDS     (NW),
      .BASE_ADDR     (BA),
      .RELEASE_DELAY (RD)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .abort         (abort),
      .byte_valid    (byte_valid),
      .byte_data     (byte_data),
      .byte_ready    (byte_ready),
      .cpu_reset     (cpu_reset),
      .Ext_MemWrite  (Ext_MemWrite),
      .Ext_WriteData (Ext_WriteData),
      .Ext_DataAdr   (Ext_DataAdr),
      .busy          (busy),
      .done          (done),
      .word_count    (word_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every strobe must match the head of the expected queue.
   always @(negedge clk) begin
      if (reset === 1'b0 && Ext_MemWrite === 1'b1) begin
         strobe_cnt++;
         last_strobe_cyc = cyc;
         check1("ready_low_in_write", byte_ready, 1'b0);
         if (exp_q.size() == 0) begin
            check32("unexpected_write", Ext_DataAdr, 32'hFFFF_FFFF);
         end else begin
            mon_e = exp_q.pop_front();
            check32("write_addr", Ext_DataAdr, mon_e[63:32]);
            check32("write_data", Ext_WriteData, mon_e[31:0]);
         end
      end
   end

   task automatic expect_write(input logic [31:0] addr, input logic [31:0] data);
      exp_q.push_back({addr, data});
      exp_writes++;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (byte_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) check1("byte_ready_timeout", byte_ready, 1'b1);
      @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int i = 0; i < 4; i++) begin
         if (max_gap > 0) begin
            byte_valid = 1'b0;
            repeat ($urandom_range(max_gap, 0)) @(negedge clk);
         end
         send_byte(w[8*i +: 8]);
      end
      byte_valid = 1'b0;
   endtask

   task automatic wait_run(output int fc);
      int t;
      t = 0;
      while (cpu_reset !== 1'b0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) check1("cpu_release_timeout", cpu_reset, 1'b0);
      fc = cyc;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // Idle after reset: byte_valid toggling must not be accepted.
      check32("rst_wdata", Ext_WriteData, 32'h0);
      check32("rst_addr", Ext_DataAdr, BA);
      for (int i = 0; i < 10; i++) begin
         byte_valid = 1'($urandom_range(1, 0));
         byte_data  = 8'($urandom_range(255, 0));
         @(negedge clk);
         check1("idle_cpu_reset", cpu_reset, 1'b1);
         check1("idle_memwrite", Ext_MemWrite, 1'b0);
         check1("idle_ready", byte_ready, 1'b0);
         check1("idle_busy", busy, 1'b0);
         check1("idle_done", done, 1'b0);
         check32("idle_count", {16'd0, word_count}, 32'd0);
      end
      byte_valid = 1'b0;

      // Abort in IDLE releases the CPU without a load.
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check1("idle_abort_busy", busy, 1'b1);
      wait_run(fall_cyc);
      check1("idle_abort_done", done, 1'b0);
      check32("idle_abort_strobes", strobe_cnt, 32'd0);

      // Back-to-back load of two words.
      expect_write(32'h0000_0100, 32'h4433_2211);
      expect_write(32'h0000_0104, 32'h8877_6655);
      pulse_start();
      check1("load1_cpu_reset", cpu_reset, 1'b1);
      check1("load1_busy", busy, 1'b1);
      send_word(32'h4433_2211, 0);
      send_word(32'h8877_6655, 0);
      wait_run(fall_cyc);
      // Strobe seen in the cycle after edge k; cpu_reset low after edge k+RD+2.
      check32("load1_release_latency", fall_cyc - last_strobe_cyc, RD + 2);
      check1("load1_done", done, 1'b1);
      check32("load1_count", {16'd0, word_count}, 32'd2);
      check32("load1_queue_empty", exp_q.size(), 32'd0);

      // Start in RUN with gapped bytes rewrites the image from BASE_ADDR.
      expect_write(32'h0000_0100, 32'hDDCC_BBAA);
      expect_write(32'h0000_0104, 32'h0F0E_0D0C);
      pulse_start();
      check1("rerun_cpu_reset", cpu_reset, 1'b1);
      check32("rerun_count", {16'd0, word_count}, 32'd0);
      check1("rerun_done_cleared", done, 1'b0);
      send_word(32'hDDCC_BBAA, 3);
      send_word(32'h0F0E_0D0C, 3);
      wait_run(fall_cyc);
      check1("gapped_done", done, 1'b1);
      check32("gapped_count", {16'd0, word_count}, 32'd2);
      check32("gapped_strobes", strobe_cnt, 32'd4);

      // Abort after 6 of 8 bytes: only the first word is written.
      expect_write(32'h0000_0100, 32'h1357_9BDF);
      pulse_start();
      send_word(32'h1357_9BDF, 0);
      send_byte(8'h01);
      send_byte(8'h02);
      byte_valid = 1'b0;
      abort = 1'b1;
      ab_cyc = cyc;
      @(negedge clk);
      abort = 1'b0;
      wait_run(fall_cyc);
      check32("abort_release_latency", fall_cyc - ab_cyc, RD + 2);
      check32("abort_count", {16'd0, word_count}, 32'd1);
      check1("abort_done", done, 1'b0);
      check32("abort_strobes", strobe_cnt, 32'd5);

      // Reset mid-COLLECT returns outputs to reset values without a clock edge.
      expect_write(32'h0000_0100, 32'hCAFE_F00D);
      pulse_start();
      send_word(32'hCAFE_F00D, 0);
      send_byte(8'h99);
      byte_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check1("async_cpu_reset", cpu_reset, 1'b1);
      check1("async_memwrite", Ext_MemWrite, 1'b0);
      check1("async_ready", byte_ready, 1'b0);
      check1("async_busy", busy, 1'b0);
      check1("async_done", done, 1'b0);
      check32("async_count", {16'd0, word_count}, 32'd0);
      check32("async_wdata", Ext_WriteData, 32'h0);
      check32("async_addr", Ext_DataAdr, BA);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Reload after reset starts again at BASE_ADDR with a clean packer.
      expect_write(32'h0000_0100, 32'h0403_0201);
      expect_write(32'h0000_0104, 32'hF0E0_D0C0);
      pulse_start();
      send_word(32'h0403_0201, 0);
      send_word(32'hF0E0_D0C0, 1);
      wait_run(fall_cyc);
      check1("reload_done", done, 1'b1);
      check32("reload_count", {16'd0, word_count}, 32'd2);

      repeat (3) @(negedge clk);
      check32("final_queue_empty", exp_q.size(), 32'd0);
      check32("final_strobe_count", strobe_cnt, exp_writes);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
